// File: rtl/apb4_mem_slave_if.sv
// APB4 completer bus bundle for apb4_mem_slave.
// Signals: PADDR/PWRITE/PWDATA/PSTRB/PSELx/PENABLE driven by the requester,
// PRDATA/PREADY/PSLVERR driven by the completer. Clock and reset stay outside.
interface apb4_mem_slave_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 12
);
    logic [ADDR_WIDTH-1:0]     PADDR;
    logic                      PWRITE;
    logic [DATA_WIDTH-1:0]     PWDATA;
    logic [DATA_WIDTH/8-1:0]   PSTRB;
    logic                      PSELx;
    logic                      PENABLE;
    logic [DATA_WIDTH-1:0]     PRDATA;
    logic                      PREADY;
    logic                      PSLVERR;

    modport slave (
        input  PADDR, PWRITE, PWDATA, PSTRB, PSELx, PENABLE,
        output PRDATA, PREADY, PSLVERR
    );

    modport master (
        output PADDR, PWRITE, PWDATA, PSTRB, PSELx, PENABLE,
        input  PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb4_mem_slave.sv
// Parametrised APB4 completer backed by a word-addressed memory array.
// Supports PSTRB byte-lane writes, a read-only low region, configurable wait
// states and PSLVERR for out-of-range, misaligned or read-only-write accesses.
// Ports:
//   i_clk   - APB clock (PCLK), rising edge
//   i_reset - synchronous, active-high reset
//   apb     - APB4 bus (slave modport); PRDATA/PREADY/PSLVERR are registered
// DATA_WIDTH must be 8, 16 or 32; WAIT_STATES must be 0..15.
module apb4_mem_slave #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned ADDR_WIDTH  = 12,
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned RO_WORDS    = 0,
    parameter int unsigned WAIT_STATES = 0
) (
    input logic             i_clk,
    input logic             i_reset,
    apb4_mem_slave_if.slave apb
);

    localparam int unsigned NumLanes = DATA_WIDTH / 8;
    localparam int unsigned Lsb      = $clog2(NumLanes);
    localparam int unsigned IdxW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]  WaitInit = 4'(WAIT_STATES);

    typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

    state_e                state_q, state_d;
    logic [3:0]            wait_q, wait_d;
    logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
    logic                  pready_q, pready_d;
    logic                  pslverr_q, pslverr_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic                  wr_en;

    // Address decode
    logic [ADDR_WIDTH-Lsb-1:0] word_idx;
    logic [31:0]               idx_ext;
    logic [IdxW-1:0]           mem_idx;
    logic                      err_addr, err_align, err_ro, err;

    assign word_idx = apb.PADDR[ADDR_WIDTH-1:Lsb];
    assign idx_ext  = 32'(word_idx);
    assign mem_idx  = idx_ext[IdxW-1:0];
    assign err_addr = idx_ext >= DEPTH;

    if (Lsb == 0) begin : gen_no_align
        assign err_align = 1'b0;
    end else begin : gen_align
        assign err_align = |apb.PADDR[Lsb-1:0];
    end

    if (RO_WORDS == 0) begin : gen_no_ro
        assign err_ro = 1'b0;
    end else begin : gen_ro
        assign err_ro = apb.PWRITE && (idx_ext < RO_WORDS);
    end

    assign err = err_addr | err_align | err_ro;

    // Expand PSTRB into a per-bit write mask
    logic [DATA_WIDTH-1:0] wr_mask;
    for (genvar g = 0; g < NumLanes; g++) begin : gen_mask
        assign wr_mask[8*g +: 8] = {8{apb.PSTRB[g]}};
    end

    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        prdata_d  = prdata_q;
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        wr_en     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (apb.PSELx && !apb.PENABLE) begin
                    wait_d  = WaitInit;
                    state_d = StAccess;
                end
            end
            StAccess: begin
                if (!apb.PSELx) begin
                    state_d = StIdle;
                end else if (!apb.PENABLE) begin
                    // Setup seen again mid-transfer: treat as a fresh setup
                    wait_d = WaitInit;
                end else if (wait_q != 4'd0) begin
                    wait_d = wait_q - 4'd1;
                end else begin
                    pready_d  = 1'b1;
                    pslverr_d = err;
                    if (err || apb.PWRITE) begin
                        prdata_d = '0;
                    end else begin
                        prdata_d = mem_q[mem_idx];
                    end
                    wr_en   = apb.PWRITE && !err;
                    state_d = StDone;
                end
            end
            StDone: begin
                // A setup overlapping the PREADY cycle chains straight into ACCESS
                if (apb.PSELx && !apb.PENABLE) begin
                    wait_d  = WaitInit;
                    state_d = StAccess;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q   <= StIdle;
            wait_q    <= '0;
            prdata_q  <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            prdata_q  <= prdata_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            mem_q <= '{default: '0};
        end else if (wr_en) begin
            mem_q[mem_idx] <= (mem_q[mem_idx] & ~wr_mask) | (apb.PWDATA & wr_mask);
        end
    end

    assign apb.PRDATA  = prdata_q;
    assign apb.PREADY  = pready_q;
    assign apb.PSLVERR = pslverr_q;

endmodule

// File: tb/tb_apb4_mem_slave.sv
// Directed bench for apb4_mem_slave. Two instances share one requester:
// u_dut0 (no wait states, 2 read-only words) and u_dut1 (3 wait states).
module tb_apb4_mem_slave;

    logic        clk;
    logic        rst;
    logic [11:0] m_addr;
    logic        m_write;
    logic [31:0] m_wdata;
    logic [3:0]  m_strb;
    logic        m_psel;
    logic        m_penable;
    int          dut_sel;

    logic [31:0] s_rdata;
    logic        s_ready;
    logic        s_err;

    int n_checks;
    int n_pass;

    apb4_mem_slave_if #(.DATA_WIDTH(32), .ADDR_WIDTH(12)) bus0 ();
    apb4_mem_slave_if #(.DATA_WIDTH(32), .ADDR_WIDTH(12)) bus1 ();

    assign bus0.PADDR   = m_addr;
    assign bus0.PWRITE  = m_write;
    assign bus0.PWDATA  = m_wdata;
    assign bus0.PSTRB   = m_strb;
    assign bus0.PSELx   = m_psel && (dut_sel == 0);
    assign bus0.PENABLE = m_penable;
    assign bus1.PADDR   = m_addr;
    assign bus1.PWRITE  = m_write;
    assign bus1.PWDATA  = m_wdata;
    assign bus1.PSTRB   = m_strb;
    assign bus1.PSELx   = m_psel && (dut_sel == 1);
    assign bus1.PENABLE = m_penable;

    assign s_rdata = (dut_sel == 0) ? bus0.PRDATA  : bus1.PRDATA;
    assign s_ready = (dut_sel == 0) ? bus0.PREADY  : bus1.PREADY;
    assign s_err   = (dut_sel == 0) ? bus0.PSLVERR : bus1.PSLVERR;

    apb4_mem_slave #(
        .DATA_WIDTH(32), .ADDR_WIDTH(12), .DEPTH(16), .RO_WORDS(2), .WAIT_STATES(0)
    ) u_dut0 (
        .i_clk  (clk),
        .i_reset(rst),
        .apb    (bus0)
    );

    apb4_mem_slave #(
        .DATA_WIDTH(32), .ADDR_WIDTH(12), .DEPTH(16), .RO_WORDS(0), .WAIT_STATES(3)
    ) u_dut1 (
        .i_clk  (clk),
        .i_reset(rst),
        .apb    (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One full transfer. Cycle 1 is the setup cycle; rdy_cyc is the cycle in
    // which PREADY is seen (-1 if never). rdy_after/err_after sample one cycle later.
    task automatic xfer(input logic wr, input logic [11:0] addr, input logic [31:0] wdata,
                        input logic [3:0] strb, output logic [31:0] rdata, output logic err,
                        output int rdy_cyc, output logic rdy_after, output logic err_after);
        int cyc;
        bit seen;
        @(posedge clk); #1;
        m_psel = 1'b1; m_penable = 1'b0; m_write = wr; m_addr = addr;
        m_wdata = wdata; m_strb = strb;
        cyc = 1; seen = 1'b0; rdata = 'x; err = 1'bx; rdy_cyc = -1;
        @(posedge clk); #1;
        m_penable = 1'b1; cyc = 2;
        for (int n = 0; n < 40 && !seen; n++) begin
            @(negedge clk);
            if (s_ready) begin
                seen = 1'b1; rdata = s_rdata; err = s_err; rdy_cyc = cyc;
            end else begin
                @(posedge clk); #1;
                cyc++;
            end
        end
        @(posedge clk); #1;
        m_psel = 1'b0; m_penable = 1'b0;
        @(negedge clk);
        rdy_after = s_ready;
        err_after = s_err;
    endtask

    task automatic test_reset();
        rst = 1'b1; m_psel = 1'b0; m_penable = 1'b0; m_write = 1'b0;
        m_addr = '0; m_wdata = '0; m_strb = '0; dut_sel = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++; if (bus0.PREADY !== 1'b0) $display("FAIL rst_pready0: got %b want 0", bus0.PREADY); else n_pass++;
        n_checks++; if (bus0.PSLVERR !== 1'b0) $display("FAIL rst_pslverr0: got %b want 0", bus0.PSLVERR); else n_pass++;
        n_checks++; if (bus0.PRDATA !== 32'h0) $display("FAIL rst_prdata0: got %h want 0", bus0.PRDATA); else n_pass++;
        n_checks++; if (bus1.PREADY !== 1'b0) $display("FAIL rst_pready1: got %b want 0", bus1.PREADY); else n_pass++;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_write_read();
        logic [31:0] rd; logic er, ra, ea; int cy;
        dut_sel = 0;
        xfer(1'b1, 12'h008, 32'hDEADBEEF, 4'hF, rd, er, cy, ra, ea);
        n_checks++; if (cy !== 3) $display("FAIL wr_cycle: got %0d want 3", cy); else n_pass++;
        n_checks++; if (er !== 1'b0) $display("FAIL wr_err: got %b want 0", er); else n_pass++;
        n_checks++; if (ra !== 1'b0) $display("FAIL wr_pready_width: got %b want 0", ra); else n_pass++;
        xfer(1'b0, 12'h008, 32'h0, 4'h0, rd, er, cy, ra, ea);
        n_checks++; if (rd !== 32'hDEADBEEF) $display("FAIL rd_data: got %h want deadbeef", rd); else n_pass++;
        n_checks++; if (er !== 1'b0) $display("FAIL rd_err: got %b want 0", er); else n_pass++;
        n_checks++; if (cy !== 3) $display("FAIL rd_cycle: got %0d want 3", cy); else n_pass++;
    endtask

    task automatic test_strobe();
        logic [31:0] rd; logic er, ra, ea; int cy;
        dut_sel = 0;
        xfer(1'b1, 12'h008, 32'h11223344, 4'h5, rd, er, cy, ra, ea);
        xfer(1'b0, 12'h008, 32'h0, 4'h0, rd, er, cy, ra, ea);
        n_checks++; if (rd !== 32'hDE22BE44) $display("FAIL strb5_data: got %h want de22be44", rd); else n_pass++;
        xfer(1'b1, 12'h008, 32'hFFFFFFFF, 4'h0, rd, er, cy, ra, ea);
        n_checks++; if (er !== 1'b0) $display("FAIL strb0_err: got %b want 0", er); else n_pass++;
        xfer(1'b0, 12'h008, 32'h0, 4'h0, rd, er, cy, ra, ea);
        n_checks++; if (rd !== 32'hDE22BE44) $display("FAIL strb0_data: got %h want de22be44", rd); else n_pass++;
        // Top word of the array is in range
        xfer(1'b1, 12'h03C, 32'h12345678, 4'hF, rd, er, cy, ra, ea);
        xfer(1'b0, 12'h03C, 32'h0, 4'h0, rd, er, cy, ra, ea);
        n_checks++; if (rd !== 32'h12345678) $display("FAIL top_word_data: got %h want 12345678", rd); else n_pass++;
        n_checks++; if (er !== 1'b0) $display("FAIL top_word_err: got %b want 0", er); else n_pass++;
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic er, ra, ea; int cy;
        dut_sel = 0;
        // PRDATA currently holds 12345678 from the previous read
        xfer(1'b0, 12'h040, 32'h0, 4'h0, rd, er, cy, ra, ea);
        n_checks++; if (er !== 1'b1) $display("FAIL oor_err: got %b want 1", er); else n_pass++;
        n_checks++; if (rd !== 32'h0) $display("FAIL oor_data: got %h want 0", rd); else n_pass++;
        n_checks++; if (ea !== 1'b0) $display("FAIL oor_err_clear: got %b want 0", ea); else n_pass++;
        xfer(1'b1, 12'h006, 32'hFFFFFFFF, 4'hF, rd, er, cy, ra, ea);
        n_checks++; if (er !== 1'b1) $display("FAIL misalign6_err: got %b want 1", er); else n_pass++;
        xfer(1'b1, 12'h00A, 32'hFFFFFFFF, 4'hF, rd, er, cy, ra, ea);
        n_checks++; if (er !== 1'b1) $display("FAIL misalignA_err: got %b want 1", er); else n_pass++;
        xfer(1'b0, 12'h008, 32'h0, 4'h0, rd, er, cy, ra, ea);
        n_checks++; if (rd !== 32'hDE22BE44) $display("FAIL misalign_nochange: got %h want de22be44", rd); else n_pass++;
        xfer(1'b1, 12'h000, 32'hA5A5A5A5, 4'hF, rd, er, cy, ra, ea);
        n_checks++; if (er !== 1'b1) $display("FAIL ro_err: got %b want 1", er); else n_pass++;
        xfer(1'b0, 12'h000, 32'h0, 4'h0, rd, er, cy, ra, ea);
        n_checks++; if (rd !== 32'h0) $display("FAIL ro_nochange: got %h want 0", rd); else n_pass++;
        n_checks++; if (er !== 1'b0) $display("FAIL ro_read_err: got %b want 0", er); else n_pass++;
    endtask

    task automatic test_wait_states();
        logic [31:0] rd; logic er, ra, ea; int cy;
        dut_sel = 1;
        xfer(1'b1, 12'h010, 32'hA5A50F0F, 4'hF, rd, er, cy, ra, ea);
        n_checks++; if (cy !== 6) $display("FAIL ws_wr_cycle: got %0d want 6", cy); else n_pass++;
        xfer(1'b0, 12'h010, 32'h0, 4'h0, rd, er, cy, ra, ea);
        n_checks++; if (cy !== 6) $display("FAIL ws_rd_cycle: got %0d want 6", cy); else n_pass++;
        n_checks++; if (rd !== 32'hA5A50F0F) $display("FAIL ws_rd_data: got %h want a5a50f0f", rd); else n_pass++;
        n_checks++; if (ra !== 1'b0) $display("FAIL ws_pready_width: got %b want 0", ra); else n_pass++;
    endtask

    task automatic test_reset_abort();
        logic [31:0] rd; logic er, ra, ea; int cy;
        dut_sel = 1;
        @(posedge clk); #1;
        m_psel = 1'b1; m_penable = 1'b0; m_write = 1'b1; m_addr = 12'h004;
        m_wdata = 32'hCAFEF00D; m_strb = 4'hF;
        @(posedge clk); #1;
        m_penable = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; m_psel = 1'b0; m_penable = 1'b0;
        @(negedge clk);
        n_checks++; if (bus1.PREADY !== 1'b0) $display("FAIL abort_pready: got %b want 0", bus1.PREADY); else n_pass++;
        n_checks++; if (bus1.PSLVERR !== 1'b0) $display("FAIL abort_pslverr: got %b want 0", bus1.PSLVERR); else n_pass++;
        n_checks++; if (bus1.PRDATA !== 32'h0) $display("FAIL abort_prdata: got %h want 0", bus1.PRDATA); else n_pass++;
        xfer(1'b0, 12'h004, 32'h0, 4'h0, rd, er, cy, ra, ea);
        n_checks++; if (rd !== 32'h0) $display("FAIL abort_word1: got %h want 0", rd); else n_pass++;
        xfer(1'b0, 12'h010, 32'h0, 4'h0, rd, er, cy, ra, ea);
        n_checks++; if (rd !== 32'h0) $display("FAIL abort_cleared: got %h want 0", rd); else n_pass++;
    endtask

    // Second setup is driven during the first PREADY cycle; counting that
    // overlapped cycle as cycle 1, the second PREADY must land in cycle 3.
    task automatic test_back_to_back();
        int cyc, got_cyc;
        bit seen;
        logic [31:0] rd;
        logic er;
        dut_sel = 0;
        @(posedge clk); #1;
        m_psel = 1'b1; m_penable = 1'b0; m_write = 1'b1; m_addr = 12'h00C;
        m_wdata = 32'h0BADCAFE; m_strb = 4'hF;
        @(posedge clk); #1;
        m_penable = 1'b1;
        seen = 1'b0;
        for (int n = 0; n < 10 && !seen; n++) begin
            @(negedge clk);
            if (s_ready) seen = 1'b1;
            else begin @(posedge clk); #1; end
        end
        n_checks++; if (seen !== 1'b1) $display("FAIL b2b_first_pready: got %b want 1", seen); else n_pass++;
        m_penable = 1'b0; m_write = 1'b0; m_addr = 12'h00C;
        cyc = 1; got_cyc = -1; seen = 1'b0; rd = 'x; er = 1'bx;
        @(posedge clk); #1;
        m_penable = 1'b1; cyc = 2;
        for (int n = 0; n < 10 && !seen; n++) begin
            @(negedge clk);
            if (s_ready) begin
                seen = 1'b1; got_cyc = cyc; rd = s_rdata; er = s_err;
            end else begin
                @(posedge clk); #1;
                cyc++;
            end
        end
        @(posedge clk); #1;
        m_psel = 1'b0; m_penable = 1'b0;
        n_checks++; if (got_cyc !== 3) $display("FAIL b2b_cycle: got %0d want 3", got_cyc); else n_pass++;
        n_checks++; if (rd !== 32'h0BADCAFE) $display("FAIL b2b_data: got %h want 0badcafe", rd); else n_pass++;
        n_checks++; if (er !== 1'b0) $display("FAIL b2b_err: got %b want 0", er); else n_pass++;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        test_reset();
        test_write_read();
        test_strobe();
        test_errors();
        test_wait_states();
        test_reset_abort();
        test_back_to_back();
        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish want finish before 200000");
        $fatal(1, "bench timeout");
    end

endmodule
